// File: rtl/data_sram_like_bridge.sv
// Bridges the memory stage's single-cycle sram port to an sram-like bus,
// stalling the pipeline until one full transaction completes per access.
module data_sram_like_bridge (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   input  logic        longest_stall,
   output logic [31:0] data_sram_rdata,
   output logic        d_stall,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic [1:0]  dbgState
);

   // Handshake: a request transfers on a cycle where data_req and data_addr_ok
   // are both 1; data_data_ok completes only an accepted request (possibly in
   // that same cycle) and is ignored whenever no request is outstanding.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } stateT;

   stateT       state;
   logic [31:0] rdataReg;
   logic [1:0]  reqSize;
   logic [1:0]  reqOffset;
   logic        reqActive;
   logic        unusedAddrLow;

   assign unusedAddrLow = ^data_sram_addr[1:0];

   assign reqActive = ((state == IDLE) && data_sram_en) || (state == ADDR);

   assign data_req        = !rst && reqActive;
   assign d_stall         = !rst && data_sram_en && (state != DONE);
   assign data_wr         = |data_sram_wen;
   assign data_size       = reqSize;
   assign data_addr       = {data_sram_addr[31:2], reqOffset};
   assign data_wdata      = data_sram_wdata;
   assign data_sram_rdata = rdataReg;
   assign dbgState        = state;

   // Byte-enable patterns map onto the narrowest naturally aligned transfer;
   // unrecognised patterns fall back to a full word.
   always_comb begin
      reqSize   = 2'd2;
      reqOffset = 2'b00;
      if (data_wr) begin
         case (data_sram_wen)
            4'b0011: begin reqSize = 2'd1; reqOffset = 2'b00; end
            4'b1100: begin reqSize = 2'd1; reqOffset = 2'b10; end
            4'b0001: begin reqSize = 2'd0; reqOffset = 2'b00; end
            4'b0010: begin reqSize = 2'd0; reqOffset = 2'b01; end
            4'b0100: begin reqSize = 2'd0; reqOffset = 2'b10; end
            4'b1000: begin reqSize = 2'd0; reqOffset = 2'b11; end
            default: begin reqSize = 2'd2; reqOffset = 2'b00; end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rdataReg <= 32'd0;
      end else begin
         case (state)
            IDLE, ADDR: begin
               if (reqActive && data_addr_ok) begin
                  if (data_data_ok) begin
                     rdataReg <= data_rdata;
                     state    <= DONE;
                  end else begin
                     state <= DATA;
                  end
               end else if (reqActive) begin
                  state <= ADDR;
               end
            end
            DATA: begin
               if (data_data_ok) begin
                  rdataReg <= data_rdata;
                  state    <= DONE;
               end
            end
            DONE: begin
               // Hold the result until the rest of the pipeline lets go.
               if (!longest_stall) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Self-checking bench for data_sram_like_bridge: directed scenarios followed
// by randomized pipeline/slave traffic checked against a transaction model.
module tb_data_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        longest_stall;
  logic [31:0] data_sram_rdata;
  logic        d_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [1:0]  dbg_state;

  data_sram_like_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .longest_stall   (longest_stall),
    .data_sram_rdata (data_sram_rdata),
    .d_stall         (d_stall),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata),
    .dbgState        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];  // captured read data, in completion order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // A pipeline access raises a request; the request waits for acceptance,
  // then for its data; the result is then held until the pipeline moves on.
  bit          m_wait_addr;
  bit          m_wait_data;
  bit          m_hold;
  logic [31:0] m_rdata;
  int          model_acc;
  int          dut_acc;
  bit          last_stall;

  function automatic logic [3:0] exp_size_off(input logic [3:0] wen);
    if (wen == 4'b0000) return {2'd2, 2'd0};
    if ($countones(wen) == 1) begin
      for (int i = 0; i < 4; i++)
        if (wen[i]) return {2'd0, 2'(i)};
    end
    if (wen == 4'b0011) return {2'd1, 2'd0};
    if (wen == 4'b1100) return {2'd1, 2'd2};
    return {2'd2, 2'd0};
  endfunction

  function automatic logic [1:0] exp_phase();
    if (m_hold) return 2'd3;
    if (m_wait_data) return 2'd2;
    if (m_wait_addr) return 2'd1;
    return 2'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ls, input logic aok,
                       input logic dok, input logic [31:0] rd);
    logic [3:0] so;
    logic       e_req;
    logic       e_stall;
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    longest_stall   = ls;
    data_addr_ok    = aok;
    data_data_ok    = dok;
    data_rdata      = rd;
    @(negedge clk);
    so      = exp_size_off(wen);
    e_req   = !rst && (m_wait_addr || (en && !m_wait_data && !m_hold));
    e_stall = !rst && en && !m_hold;
    check("data_req", data_req, e_req);
    check("d_stall", d_stall, e_stall);
    check("rdata", data_sram_rdata, m_rdata);
    check("state", dbg_state, exp_phase());
    check("data_wr", data_wr, |wen);
    check("data_size", data_size, so[3:2]);
    check("data_addr", data_addr, {addr[31:2], so[1:0]});
    check("data_wdata", data_wdata, wdata);
    if (data_req && data_addr_ok) dut_acc++;
    last_stall = e_stall;
  endtask

  task automatic advance();
    if (rst) begin
      m_wait_addr = 0;
      m_wait_data = 0;
      m_hold      = 0;
      m_rdata     = 32'd0;
    end else if (m_hold) begin
      if (!longest_stall) m_hold = 0;
    end else if (m_wait_data) begin
      if (data_data_ok) begin
        m_rdata = data_rdata;
        exp_q.push_back(data_rdata);
        m_wait_data = 0;
        m_hold      = 1;
      end
    end else if (m_wait_addr || data_sram_en) begin
      m_wait_addr = 0;
      if (data_addr_ok) begin
        model_acc++;
        if (data_data_ok) begin
          m_rdata = data_rdata;
          exp_q.push_back(data_rdata);
          m_hold = 1;
        end else begin
          m_wait_data = 1;
        end
      end else begin
        m_wait_addr = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0]  wen_pool[12] = '{4'b0000, 4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001,
                                4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b1010, 4'b0111};
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wen;
  logic        r_en;
  logic        r_ls;
  logic        r_aok;
  logic        r_dok;
  int          acc_before;
  bit          can_advance;

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    m_rdata = 32'd0;

    // reset holds request and stall low even with an access present
    drive(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b1, 32'h9999_9999);
    check("rst_req", data_req, 1'b0);
    check("rst_stall", d_stall, 1'b0);
    advance();
    rst = 1'b0;

    // read with addr_ok in cycle 0 and data_ok in cycle 2
    drive(1'b1, 4'h0, 32'h1000_0006, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("rd_addr", data_addr, 32'h1000_0004);
    check("rd_size", data_size, 2'd2);
    check("rd_wr", data_wr, 1'b0);
    check("rd_stall0", d_stall, 1'b1);
    advance();
    drive(1'b1, 4'h0, 32'h1000_0006, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rd_stall1", d_stall, 1'b1);
    advance();
    drive(1'b1, 4'h0, 32'h1000_0006, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check("rd_stall2", d_stall, 1'b1);
    advance();
    drive(1'b1, 4'h0, 32'h1000_0006, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rd_stall3", d_stall, 1'b0);
    check("rd_data", data_sram_rdata, 32'hDEAD_BEEF);
    advance();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rd_data_kept", data_sram_rdata, 32'hDEAD_BEEF);
    advance();

    // byte store to lane 2
    drive(1'b1, 4'b0100, 32'h0000_0010, 32'h00AB_0000, 1'b0, 1'b1, 1'b0, 32'h0);
    check("sb_size", data_size, 2'd0);
    check("sb_addr", data_addr, 32'h0000_0012);
    check("sb_wr", data_wr, 1'b1);
    check("sb_wdata", data_wdata, 32'h00AB_0000);
    advance();
    drive(1'b1, 4'b0100, 32'h0000_0010, 32'h00AB_0000, 1'b0, 1'b0, 1'b1, 32'h0);
    advance();
    drive(1'b1, 4'b0100, 32'h0000_0010, 32'h00AB_0000, 1'b0, 1'b0, 1'b0, 32'h0);
    advance();

    // addr_ok withheld for 3 cycles
    acc_before = dut_acc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h0, 32'h2000_0100, 32'h0, 1'b0, (i == 3), 1'b0, 32'h0);
      check("wait_req", data_req, 1'b1);
      check("wait_stall", d_stall, 1'b1);
      advance();
    end
    drive(1'b1, 4'h0, 32'h2000_0100, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0BAD_0001);
    check("wait_req_data", data_req, 1'b0);
    check("wait_stall_data", d_stall, 1'b1);
    advance();
    drive(1'b1, 4'h0, 32'h2000_0100, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    check("wait_stall_done", d_stall, 1'b0);
    advance();
    check("wait_one_txn", dut_acc - acc_before, 1);

    // same-cycle addr_ok and data_ok
    drive(1'b1, 4'h0, 32'h3000_0000, 32'h0, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
    advance();
    drive(1'b1, 4'h0, 32'h3000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("same_done", dbg_state, 2'd3);
    check("same_data", data_sram_rdata, 32'h1234_5678);
    advance();

    // longest_stall holds DONE for 5 cycles; bus noise meanwhile is ignored
    acc_before = dut_acc;
    drive(1'b1, 4'h0, 32'h3000_0040, 32'h0, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'h0, 32'h3000_0040, 32'h0, 1'b1, 1'b1, 1'b1, 32'h5555_5555);
      check("ls_state", dbg_state, 2'd3);
      check("ls_stall", d_stall, 1'b0);
      check("ls_req", data_req, 1'b0);
      check("ls_data", data_sram_rdata, 32'hCAFE_F00D);
      advance();
    end
    drive(1'b1, 4'h0, 32'h3000_0040, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("ls_fall_state", dbg_state, 2'd3);
    advance();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("ls_idle", dbg_state, 2'd0);
    check("ls_one_txn", dut_acc - acc_before, 1);
    advance();

    // reset while waiting for data
    drive(1'b1, 4'h0, 32'h4000_0000, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    advance();
    drive(1'b1, 4'h0, 32'h4000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("mid_data", dbg_state, 2'd2);
    advance();
    rst = 1'b1;
    drive(1'b1, 4'h0, 32'h4000_0000, 32'h0, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
    advance();
    rst = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8888_8888);
    check("rst_idle", dbg_state, 2'd0);
    check("rst_req0", data_req, 1'b0);
    check("rst_rdata0", data_sram_rdata, 32'h0);
    advance();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("rst_ignored", data_sram_rdata, 32'h0);
    advance();

    // randomized traffic
    exp_q.delete();
    r_en = 1'b0; r_wen = 4'h0; r_addr = 32'h0; r_wdata = 32'h0; r_ls = 1'b0;
    can_advance = 1;
    for (int n = 0; n < 3000; n++) begin
      if (can_advance) begin
        r_en    = ($urandom_range(0, 3) != 0);
        r_wen   = wen_pool[$urandom_range(0, 11)];
        r_addr  = $urandom;
        r_wdata = $urandom;
      end
      r_ls = ($urandom_range(0, 2) == 0);
      if (m_wait_data) begin
        r_aok = 1'b0;
        r_dok = ($urandom_range(0, 2) == 0);
      end else if (m_hold || (!m_wait_addr && !r_en)) begin
        r_aok = $urandom_range(0, 1);
        r_dok = $urandom_range(0, 1);
      end else begin
        r_aok = $urandom_range(0, 1);
        r_dok = r_aok && $urandom_range(0, 1);
      end
      rst = ($urandom_range(0, 199) == 0);
      drive(r_en, r_wen, r_addr, r_wdata, r_ls, r_aok, r_dok, $urandom);
      if (data_data_ok && (m_wait_data || (data_req && data_addr_ok)) && !rst) begin
        logic [31:0] exp_word;
        advance();
        exp_word = exp_q.pop_front();
        check("rand_capture", data_sram_rdata, exp_word);
      end else begin
        advance();
      end
      can_advance = rst || (!last_stall && !r_ls);
    end
    rst = 1'b0;

    check("one_txn_per_access", dut_acc, model_acc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
